hazard_scoreboard_unit: RTL and testbench

Parametrised hazard unit for the 5-stage MIPS pipeline, the next generation of the combinational hazard controller. It adds a register scoreboard for a variable-latency multiply/divide unit (MDU) with up to `MDU_DEPTH` outstanding operations. It also adds write-after-write protection, a taken-branch flush and a stall-cycle performance counter. It sits beside the datapath and drives stall, flush and forward-select controls for fetch, decode and execute.

---
 rtl/hazard_scoreboard_unit_pkg.sv | 22 ++
 rtl/hazard_scoreboard_unit_if.sv | 70 +++++++
 rtl/hazard_scoreboard_unit_reg_scoreboard.sv | 90 +++++++++
 rtl/hazard_scoreboard_unit.sv | 108 ++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared types and limits for the pipeline hazard unit.
//   fwd_sel_e     : execute-stage operand forward select
//   MDU_DEPTH_MAX : largest supported number of MDU ops in flight
//   cnt_width     : bits needed to hold a count of 0..max_val
package PipelineHazardCtrl;

  localparam int unsigned MDU_DEPTH_MAX = 4;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_DM   = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_e;

  // Width of a counter spanning 0..max_val, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Datapath <-> hazard unit control bundle.
//   master : datapath side, drives stage register indices and MDU writeback
//   slave  : hazard unit side, returns stalls, flush, forward selects, status
interface hazard_scoreboard_unit_if #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 32
);
  import PipelineHazardCtrl::*;

  localparam int unsigned REG_W = $clog2(NREG);

  // decode stage
  logic [REG_W-1:0] rs_decode;
  logic [REG_W-1:0] rt_decode;
  logic             reg_we_decode;
  logic [REG_W-1:0] wreg_dst_decode;
  logic             is_branch_decode;
  logic             branch_taken_decode;
  logic             is_mdu_decode;
  // execute stage
  logic [REG_W-1:0] rs_exe;
  logic [REG_W-1:0] rt_exe;
  logic             reg_we_exe;
  logic             mem_read_exe;
  logic [REG_W-1:0] wreg_dst_exe;
  // memory stage
  logic             reg_we_dm;
  logic             mem_read_dm;
  logic [REG_W-1:0] wreg_dst_dm;
  // writeback stage
  logic             reg_we_wrbck;
  logic [REG_W-1:0] wreg_dst_wrbck;
  // MDU result port
  logic             mdu_wb_valid;
  logic [REG_W-1:0] mdu_wb_dst;
  // controls back to the pipeline
  logic             stall_fetch;
  logic             stall_decode;
  logic             clear_exe;
  logic             flush_decode;
  fwd_sel_e         forward_srca_sel_exe;
  fwd_sel_e         forward_srcb_sel_exe;
  logic [CNT_W-1:0] stall_count;
  logic             sb_error;

  modport master (
    output rs_decode, rt_decode, reg_we_decode, wreg_dst_decode,
           is_branch_decode, branch_taken_decode, is_mdu_decode,
           rs_exe, rt_exe, reg_we_exe, mem_read_exe, wreg_dst_exe,
           reg_we_dm, mem_read_dm, wreg_dst_dm,
           reg_we_wrbck, wreg_dst_wrbck,
           mdu_wb_valid, mdu_wb_dst,
    input  stall_fetch, stall_decode, clear_exe, flush_decode,
           forward_srca_sel_exe, forward_srcb_sel_exe,
           stall_count, sb_error
  );

  modport slave (
    input  rs_decode, rt_decode, reg_we_decode, wreg_dst_decode,
           is_branch_decode, branch_taken_decode, is_mdu_decode,
           rs_exe, rt_exe, reg_we_exe, mem_read_exe, wreg_dst_exe,
           reg_we_dm, mem_read_dm, wreg_dst_dm,
           reg_we_wrbck, wreg_dst_wrbck,
           mdu_wb_valid, mdu_wb_dst,
    output stall_fetch, stall_decode, clear_exe, flush_decode,
           forward_srca_sel_exe, forward_srcb_sel_exe,
           stall_count, sb_error
  );

endinterface

// File: rtl/hazard_scoreboard_unit_reg_scoreboard.sv
// Register scoreboard for the variable-latency MDU.
// Tracks which registers await an MDU result, how many ops are in flight,
// and a sticky error for writebacks that match nothing.
//   clk, rst     : clock, synchronous active-high reset
//   issue_i      : MDU op leaves decode this cycle
//   issue_dst_i  : its destination register
//   wb_valid_i   : MDU writes the register file this cycle
//   wb_dst_i     : MDU writeback destination
//   rd_addr_i    : three lookup addresses (rs, rt, decode destination)
//   pend_o       : per lookup, register still waiting (writeback bypassed)
//   full_o       : MDU_DEPTH ops in flight
//   sb_error_o   : sticky spurious-writeback flag
module reg_scoreboard
  import PipelineHazardCtrl::*;
#(
  parameter int unsigned NREG      = 32,
  parameter int unsigned MDU_DEPTH = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          issue_i,
  input  logic [$clog2(NREG)-1:0]       issue_dst_i,
  input  logic                          wb_valid_i,
  input  logic [$clog2(NREG)-1:0]       wb_dst_i,
  input  logic [2:0][$clog2(NREG)-1:0]  rd_addr_i,
  output logic [2:0]                    pend_o,
  output logic                          full_o,
  output logic                          sb_error_o
);

  localparam int unsigned REG_W = $clog2(NREG);
  localparam int unsigned DEPTH = (MDU_DEPTH > MDU_DEPTH_MAX) ? MDU_DEPTH_MAX :
                                  (MDU_DEPTH < 1) ? 1 : MDU_DEPTH;
  localparam int unsigned OUT_W = cnt_width(DEPTH);

  logic [NREG-1:0]  pending_q, pending_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic             sb_error_q, sb_error_d;
  logic             wb_ok;

  // A writeback only counts when it matches an op actually in flight.
  assign wb_ok = wb_valid_i && (outstanding_q != '0) && pending_q[wb_dst_i];

  // Next-state: clear before set so a same-register issue wins.
  always_comb begin
    pending_d     = pending_q;
    outstanding_d = outstanding_q;
    sb_error_d    = sb_error_q | (wb_valid_i & ~wb_ok);
    if (wb_ok) begin
      pending_d[wb_dst_i] = 1'b0;
    end
    if (issue_i && (issue_dst_i != '0)) begin
      pending_d[issue_dst_i] = 1'b1;
    end
    unique case ({issue_i, wb_ok})
      2'b10: begin
        if (outstanding_q != OUT_W'(DEPTH)) begin
          outstanding_d = outstanding_q + OUT_W'(1);
        end
      end
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q     <= '0;
      outstanding_q <= '0;
      sb_error_q    <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      sb_error_q    <= sb_error_d;
    end
  end

  // Lookups see a same-cycle writeback as already cleared (write-first RF).
  always_comb begin
    pend_o = '0;
    for (int k = 0; k < 3; k++) begin
      pend_o[k] = (rd_addr_i[k] != REG_W'(0)) && pending_q[rd_addr_i[k]] &&
                  !(wb_valid_i && (wb_dst_i == rd_addr_i[k]));
    end
  end

  assign full_o     = (outstanding_q == OUT_W'(DEPTH));
  assign sb_error_o = sb_error_q;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage pipeline: operand forwarding, load-use and
// branch stalls, MDU scoreboard RAW/WAW/structural stalls, taken-branch
// flush and a saturating stall-cycle counter.
//   clk, rst : clock, synchronous active-high reset
//   hz       : slave side of hazard_scoreboard_unit_if (all stage inputs
//              and control outputs)
module hazard_scoreboard_unit
  import PipelineHazardCtrl::*;
#(
  parameter int unsigned NREG      = 32,
  parameter int unsigned MDU_DEPTH = 1,
  parameter int unsigned CNT_W     = 32
) (
  input logic                     clk,
  input logic                     rst,
  hazard_scoreboard_unit_if.slave hz
);

  localparam int unsigned REG_W = $clog2(NREG);

  logic [2:0]       pend;
  logic             sb_full;
  logic             sb_error;
  logic             is_stall_raw;
  logic             is_stall;
  logic             issue;
  logic             load_use, br_exe, br_dm, raw_haz, waw_haz, struct_haz;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  // Nonzero register equality: register 0 never creates a dependency.
  function automatic logic dep(input logic [REG_W-1:0] a,
                               input logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  function automatic fwd_sel_e fwd_pick(input logic [REG_W-1:0] src,
                                        input logic             we_dm,
                                        input logic [REG_W-1:0] dst_dm,
                                        input logic             we_wb,
                                        input logic [REG_W-1:0] dst_wb);
    if (we_dm && dep(src, dst_dm))      return FWD_DM;
    else if (we_wb && dep(src, dst_wb)) return FWD_WB;
    else                                return FWD_NONE;
  endfunction

  reg_scoreboard #(
    .NREG      (NREG),
    .MDU_DEPTH (MDU_DEPTH)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .issue_i     (issue),
    .issue_dst_i (hz.wreg_dst_decode),
    .wb_valid_i  (hz.mdu_wb_valid),
    .wb_dst_i    (hz.mdu_wb_dst),
    .rd_addr_i   ({hz.wreg_dst_decode, hz.rt_decode, hz.rs_decode}),
    .pend_o      (pend),
    .full_o      (sb_full),
    .sb_error_o  (sb_error)
  );

  // Stall causes.
  always_comb begin
    load_use   = hz.mem_read_exe && hz.reg_we_exe &&
                 (dep(hz.wreg_dst_exe, hz.rs_decode) || dep(hz.wreg_dst_exe, hz.rt_decode));
    br_exe     = hz.is_branch_decode && hz.reg_we_exe &&
                 (dep(hz.wreg_dst_exe, hz.rs_decode) || dep(hz.wreg_dst_exe, hz.rt_decode));
    br_dm      = hz.is_branch_decode && hz.mem_read_dm &&
                 (dep(hz.wreg_dst_dm, hz.rs_decode) || dep(hz.wreg_dst_dm, hz.rt_decode));
    raw_haz    = pend[0] || pend[1];
    waw_haz    = hz.reg_we_decode && pend[2];
    struct_haz = hz.is_mdu_decode && sb_full && !hz.mdu_wb_valid;
    is_stall_raw = load_use || br_exe || br_dm || raw_haz || waw_haz || struct_haz;
  end

  assign is_stall = is_stall_raw && !rst;
  assign issue    = hz.is_mdu_decode && !is_stall && !rst;

  assign hz.stall_fetch  = is_stall;
  assign hz.stall_decode = is_stall;
  assign hz.clear_exe    = is_stall;
  assign hz.flush_decode = hz.branch_taken_decode && !is_stall && !rst;

  assign hz.forward_srca_sel_exe = rst ? FWD_NONE :
      fwd_pick(hz.rs_exe, hz.reg_we_dm, hz.wreg_dst_dm, hz.reg_we_wrbck, hz.wreg_dst_wrbck);
  assign hz.forward_srcb_sel_exe = rst ? FWD_NONE :
      fwd_pick(hz.rt_exe, hz.reg_we_dm, hz.wreg_dst_dm, hz.reg_we_wrbck, hz.wreg_dst_wrbck);

  // Saturating stalled-cycle counter.
  always_comb begin
    stall_count_d = stall_count_q;
    if (is_stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign hz.stall_count = stall_count_q;
  assign hz.sb_error    = sb_error;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
module tb_hazard_scoreboard_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit_if #(.NREG(32), .CNT_W(32)) hz ();

  hazard_scoreboard_unit #(.NREG(32), .MDU_DEPTH(1), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  typedef struct {
    logic [4:0] rs_d, rt_d; logic we_d; logic [4:0] dst_d;
    logic br, tk, mdu;
    logic [4:0] rs_e, rt_e; logic we_e, mr_e; logic [4:0] dst_e;
    logic we_dm, mr_dm; logic [4:0] dst_dm;
    logic we_wb; logic [4:0] dst_wb;
    logic e_stall, e_flush; logic [1:0] e_fa, e_fb;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    hz.rs_decode = 0; hz.rt_decode = 0; hz.reg_we_decode = 0; hz.wreg_dst_decode = 0;
    hz.is_branch_decode = 0; hz.branch_taken_decode = 0; hz.is_mdu_decode = 0;
    hz.rs_exe = 0; hz.rt_exe = 0; hz.reg_we_exe = 0; hz.mem_read_exe = 0; hz.wreg_dst_exe = 0;
    hz.reg_we_dm = 0; hz.mem_read_dm = 0; hz.wreg_dst_dm = 0;
    hz.reg_we_wrbck = 0; hz.wreg_dst_wrbck = 0;
    hz.mdu_wb_valid = 0; hz.mdu_wb_dst = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic apply(input vec_t v);
    hz.rs_decode = v.rs_d; hz.rt_decode = v.rt_d; hz.reg_we_decode = v.we_d;
    hz.wreg_dst_decode = v.dst_d; hz.is_branch_decode = v.br;
    hz.branch_taken_decode = v.tk; hz.is_mdu_decode = v.mdu;
    hz.rs_exe = v.rs_e; hz.rt_exe = v.rt_e; hz.reg_we_exe = v.we_e;
    hz.mem_read_exe = v.mr_e; hz.wreg_dst_exe = v.dst_e;
    hz.reg_we_dm = v.we_dm; hz.mem_read_dm = v.mr_dm; hz.wreg_dst_dm = v.dst_dm;
    hz.reg_we_wrbck = v.we_wb; hz.wreg_dst_wrbck = v.dst_wb;
    hz.mdu_wb_valid = 0; hz.mdu_wb_dst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_cnt;
    //          rs rt we dst br tk mdu rse rte wee mre dste wdm mdm ddm wwb dwb  st fl fa fb
    vecs[0]  = '{0, 0, 0, 0,  0, 0, 0,  0,  0,  0,  0,  0,   0,  0,  0,  0,  0,   0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0,  0, 0, 0,  5,  0,  0,  0,  0,   1,  0,  5,  0,  0,   0, 0, 1, 0};
    vecs[2]  = '{0, 0, 0, 0,  0, 0, 0,  0,  5,  0,  0,  0,   0,  0,  0,  1,  5,   0, 0, 0, 2};
    vecs[3]  = '{0, 0, 0, 0,  0, 0, 0,  5,  5,  0,  0,  0,   1,  0,  5,  1,  5,   0, 0, 1, 1};
    vecs[4]  = '{0, 0, 0, 0,  0, 0, 0,  0,  0,  0,  0,  0,   1,  0,  0,  1,  0,   0, 0, 0, 0};
    vecs[5]  = '{0, 0, 0, 0,  0, 0, 0,  7,  0,  0,  0,  0,   0,  0,  7,  1,  7,   0, 0, 2, 0};
    vecs[6]  = '{8, 0, 0, 0,  0, 0, 0,  0,  0,  1,  1,  8,   0,  0,  0,  0,  0,   1, 0, 0, 0};
    vecs[7]  = '{0, 8, 0, 0,  0, 0, 0,  0,  0,  1,  1,  8,   0,  0,  0,  0,  0,   1, 0, 0, 0};
    vecs[8]  = '{0, 0, 0, 0,  0, 0, 0,  0,  0,  1,  1,  0,   0,  0,  0,  0,  0,   0, 0, 0, 0};
    vecs[9]  = '{8, 0, 0, 0,  0, 0, 0,  0,  0,  0,  1,  8,   0,  0,  0,  0,  0,   0, 0, 0, 0};
    vecs[10] = '{3, 0, 0, 0,  1, 1, 0,  0,  0,  0,  0,  0,   0,  0,  0,  0,  0,   0, 1, 0, 0};
    vecs[11] = '{3, 0, 0, 0,  1, 1, 0,  0,  0,  1,  0,  3,   0,  0,  0,  0,  0,   1, 0, 0, 0};
    vecs[12] = '{0, 4, 0, 0,  1, 0, 0,  0,  0,  0,  0,  0,   0,  1,  4,  0,  0,   1, 0, 0, 0};
    vecs[13] = '{3, 0, 0, 0,  0, 0, 0,  0,  0,  1,  0,  3,   0,  0,  0,  0,  0,   0, 0, 0, 0};
    vecs[14] = '{3, 0, 0, 0,  1, 1, 0,  0,  0,  0,  0,  0,   1,  0,  3,  0,  0,   0, 1, 0, 0};

    rst = 1'b1;
    clear_inputs();

    // Outputs forced low while reset is asserted, even with hazards present.
    apply(vecs[6]);
    hz.reg_we_dm = 1; hz.wreg_dst_dm = 5; hz.rs_exe = 5; hz.branch_taken_decode = 1;
    #1;
    chk("rst stall", 32'(hz.stall_decode), 0);
    chk("rst flush", 32'(hz.flush_decode), 0);
    chk("rst fa", 32'(hz.forward_srca_sel_exe), 0);
    do_reset();
    chk("reset stall_count", hz.stall_count, 0);
    chk("reset sb_error", 32'(hz.sb_error), 0);

    // Combinational table with an empty scoreboard.
    exp_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      apply(vecs[i]);
      #1;
      chk($sformatf("vec%0d stall_fetch", i), 32'(hz.stall_fetch), 32'(vecs[i].e_stall));
      chk($sformatf("vec%0d clear_exe", i), 32'(hz.clear_exe), 32'(vecs[i].e_stall));
      chk($sformatf("vec%0d flush", i), 32'(hz.flush_decode), 32'(vecs[i].e_flush));
      chk($sformatf("vec%0d fwd_a", i), 32'(hz.forward_srca_sel_exe), 32'(vecs[i].e_fa));
      chk($sformatf("vec%0d fwd_b", i), 32'(hz.forward_srcb_sel_exe), 32'(vecs[i].e_fb));
      if (vecs[i].e_stall) exp_cnt++;
      step();
    end
    clear_inputs();
    #1;
    chk("table stall_count", hz.stall_count, 32'(exp_cnt));

    // Load-use: one stall cycle, then the load forwards from DM.
    do_reset();
    hz.mem_read_exe = 1; hz.reg_we_exe = 1; hz.wreg_dst_exe = 8; hz.rs_decode = 8;
    #1;
    chk("lu stall", 32'(hz.stall_decode), 1);
    chk("lu clear_exe", 32'(hz.clear_exe), 1);
    step();
    clear_inputs();
    hz.mem_read_dm = 1; hz.reg_we_dm = 1; hz.wreg_dst_dm = 8; hz.rs_exe = 8;
    #1;
    chk("lu release", 32'(hz.stall_decode), 0);
    chk("lu fwd_dm", 32'(hz.forward_srca_sel_exe), 1);
    step();

    // MDU RAW: issue $9, read $9 next cycle, writeback in cycle 5.
    do_reset();
    hz.is_mdu_decode = 1; hz.reg_we_decode = 1; hz.wreg_dst_decode = 9;
    #1;
    chk("mdu issue stall", 32'(hz.stall_decode), 0);
    step();
    clear_inputs();
    hz.rs_decode = 9;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("raw cyc%0d stall", c), 32'(hz.stall_decode), 1);
      step();
    end
    hz.mdu_wb_valid = 1; hz.mdu_wb_dst = 9;
    #1;
    chk("raw bypass release", 32'(hz.stall_decode), 0);
    chk("raw stall_count", hz.stall_count, 4);
    step();
    clear_inputs();
    hz.rs_decode = 9;
    #1;
    chk("raw cleared", 32'(hz.stall_decode), 0);
    chk("raw sb_error", 32'(hz.sb_error), 0);
    step();

    // Structural with MDU_DEPTH=1.
    clear_inputs();
    hz.is_mdu_decode = 1; hz.reg_we_decode = 1; hz.wreg_dst_decode = 10;
    #1;
    chk("st first issue", 32'(hz.stall_decode), 0);
    step();
    hz.wreg_dst_decode = 11;
    #1;
    chk("st second blocked a", 32'(hz.stall_decode), 1);
    step();
    chk("st second blocked b", 32'(hz.stall_decode), 1);
    hz.mdu_wb_valid = 1; hz.mdu_wb_dst = 10;
    #1;
    chk("st coincide no stall", 32'(hz.stall_decode), 0);
    step();
    clear_inputs();
    hz.is_mdu_decode = 1; hz.reg_we_decode = 1; hz.wreg_dst_decode = 12;
    #1;
    chk("st third blocked", 32'(hz.stall_decode), 1);
    clear_inputs();
    hz.mdu_wb_valid = 1; hz.mdu_wb_dst = 11; hz.rs_decode = 10;
    #1;
    chk("st rs10 cleared", 32'(hz.stall_decode), 0);
    step();
    clear_inputs();
    hz.rs_decode = 11;
    #1;
    chk("st rs11 cleared", 32'(hz.stall_decode), 0);
    chk("st sb_error", 32'(hz.sb_error), 0);
    step();

    // WAW on a pending register.
    clear_inputs();
    hz.is_mdu_decode = 1; hz.reg_we_decode = 1; hz.wreg_dst_decode = 9;
    step();
    clear_inputs();
    hz.wreg_dst_decode = 9;
    #1;
    chk("waw no we", 32'(hz.stall_decode), 0);
    hz.reg_we_decode = 1;
    #1;
    chk("waw stall a", 32'(hz.stall_decode), 1);
    step();
    chk("waw stall b", 32'(hz.stall_decode), 1);
    hz.mdu_wb_valid = 1; hz.mdu_wb_dst = 9;
    #1;
    chk("waw release", 32'(hz.stall_decode), 0);
    step();
    clear_inputs();
    step();

    // Spurious writeback with nothing outstanding.
    hz.mdu_wb_valid = 1; hz.mdu_wb_dst = 5;
    step();
    clear_inputs();
    #1;
    chk("err set", 32'(hz.sb_error), 1);
    step();
    step();
    hz.rs_decode = 5;
    #1;
    chk("err sticky", 32'(hz.sb_error), 1);
    chk("err pending unchanged", 32'(hz.stall_decode), 0);
    hz.is_mdu_decode = 1; hz.wreg_dst_decode = 6;
    #1;
    chk("err no underflow", 32'(hz.stall_decode), 0);
    step();
    clear_inputs();
    hz.is_mdu_decode = 1; hz.wreg_dst_decode = 7;
    #1;
    chk("err count one", 32'(hz.stall_decode), 1);
    do_reset();
    chk("err cleared by rst", 32'(hz.sb_error), 0);
    hz.rs_decode = 6;
    #1;
    chk("rst clears pending", 32'(hz.stall_decode), 0);
    hz.is_mdu_decode = 1; hz.wreg_dst_decode = 7;
    #1;
    chk("rst clears outstanding", 32'(hz.stall_decode), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_inputs();

    // Taken branch: flush without hazard, deferred flush with EXE dependency.
    hz.is_branch_decode = 1; hz.branch_taken_decode = 1; hz.rs_decode = 3; hz.rt_decode = 4;
    hz.reg_we_exe = 1; hz.wreg_dst_exe = 4;
    #1;
    chk("br dep stall", 32'(hz.stall_decode), 1);
    chk("br dep no flush", 32'(hz.flush_decode), 0);
    step();
    hz.reg_we_exe = 0; hz.wreg_dst_exe = 0;
    hz.reg_we_dm = 1; hz.wreg_dst_dm = 4;
    #1;
    chk("br release stall", 32'(hz.stall_decode), 0);
    chk("br release flush", 32'(hz.flush_decode), 1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
